// File: rtl/mem_wb_elastic_if.sv
// MEM/WB boundary bundle: MEM-side beat offer, WB-side resolved writeback and flush.
interface mem_wb_elastic_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              flush;
    logic              mem_valid;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_data;
    logic [XLEN-1:0]   mem_alu_result;
    logic [XLEN-1:0]   mem_pc_plus4;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_to_reg;
    logic              mem_jal;
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_AW-1:0] wb_writereg;
    logic [XLEN-1:0]   wb_wdata;
    logic              wb_reg_write_final;
    logic              wb_we;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, mem_valid, mem_data, mem_alu_result, mem_pc_plus4, mem_rd,
               mem_reg_write, mem_mem_to_reg, mem_jal, wb_ready,
        input  mem_ready, wb_valid, wb_writereg, wb_wdata, wb_reg_write_final,
               wb_we, stall_cnt
    );

    modport slave (
        input  flush, mem_valid, mem_data, mem_alu_result, mem_pc_plus4, mem_rd,
               mem_reg_write, mem_mem_to_reg, mem_jal, wb_ready,
        output mem_ready, wb_valid, wb_writereg, wb_wdata, wb_reg_write_final,
               wb_we, stall_cnt
    );
endinterface

// File: rtl/mem_wb_elastic.sv
// Elastic MEM/WB boundary: 2-entry skid buffer resolving writeback dest/data/enable on capture,
// plus a saturating WB back-pressure counter.
module mem_wb_elastic #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned LINK_REG      = 31,
    parameter int unsigned ZERO_SUPPRESS = 1,
    parameter int unsigned CNT_W         = 16
) (
    input logic             clk,
    input logic             reset,
    mem_wb_elastic_if.slave bus
);
    typedef struct packed {
        logic [REG_AW-1:0] writereg;
        logic [XLEN-1:0]   wdata;
        logic              we;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    entry_t           main_q, main_d, skid_q, skid_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_we_q, wb_we_d;
    logic             mem_ready_q, mem_ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic   accept_c, pop_c;
    entry_t beat_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            mem_ready_q <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            mem_ready_q <= mem_ready_d;
            stall_q     <= stall_d;
        end
    end

    // Resolve the incoming beat, then next-state / next-contents
    always_comb begin
        accept_c = bus.mem_valid & mem_ready_q & ~bus.flush;
        pop_c    = wb_valid_q & bus.wb_ready;

        beat_c.writereg = bus.mem_jal ? REG_AW'(LINK_REG) : bus.mem_rd;
        beat_c.we       = (bus.mem_reg_write | bus.mem_jal) &
                          ~((ZERO_SUPPRESS != 0) && (beat_c.writereg == '0));
        beat_c.wdata    = bus.mem_jal        ? bus.mem_pc_plus4 :
                          bus.mem_mem_to_reg ? bus.mem_data     : bus.mem_alu_result;

        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        unique case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    main_d  = beat_c;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept_c && pop_c) begin
                    main_d = beat_c;
                end else if (accept_c) begin
                    skid_d  = beat_c;
                    state_d = TWO;
                end else if (pop_c) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop_c) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush overrides any movement; the counter deliberately survives it
        if (bus.flush) begin
            state_d = EMPTY;
        end

        if (wb_valid_q && !bus.wb_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        wb_valid_d  = (state_d != EMPTY);
        wb_we_d     = (state_d != EMPTY) & main_d.we;
        mem_ready_d = (state_d != TWO);
    end

    assign bus.mem_ready          = mem_ready_q;
    assign bus.wb_valid           = wb_valid_q;
    assign bus.wb_writereg        = main_q.writereg;
    assign bus.wb_wdata           = main_q.wdata;
    assign bus.wb_reg_write_final = main_q.we;
    assign bus.wb_we              = wb_we_q;
    assign bus.stall_cnt          = stall_q;
endmodule
